lift_scheduler: RTL and testbench

LIFT_SCHEDULER -- requirements
Module: lift_scheduler

---
 rtl/lift_pkg.sv | 28 ++
 rtl/lift_scheduler_if.sv | 35 +++
 rtl/lift_timer.sv | 36 +++
 rtl/lift_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_lift_scheduler.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lift_pkg.sv
// lift_pkg
//   Shared types for the lift scheduler: the FSM state enum, the movement
//   codes driven on the movement output and the travel direction type.
//   Imported by lift_scheduler_if, lift_timer and lift_scheduler.
package lift_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  // Encoding is visible on the movement port: 0 stopped, 1 up, 2 down.
  typedef enum logic [1:0] {
    STOP = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } movement_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int TIMER_WIDTH = 32;

endpackage

// File: rtl/lift_scheduler_if.sv
// lift_scheduler_if
//   Groups the request input and status outputs of the lift scheduler.
//   Ports (signals):
//     req         NUM_FLOORS  floor requests, bit i = floor i
//     cur_floor   4           current floor, binary
//     movement    2           0 stopped, 1 up, 2 down
//     door_open   1           door open indicator
//     door_closed 1           always the inverse of door_open
//     pending     NUM_FLOORS  registered outstanding requests
//     busy        1           lift active or requests outstanding
//   Modports: master drives req (call panel side), slave is the scheduler.
interface lift_scheduler_if #(
  parameter int NUM_FLOORS = 9
);
  import lift_pkg::*;

  logic [NUM_FLOORS-1:0] req;
  logic [3:0]            cur_floor;
  logic [1:0]            movement;
  logic                  door_open;
  logic                  door_closed;
  logic [NUM_FLOORS-1:0] pending;
  logic                  busy;

  modport master (
    output req,
    input  cur_floor, movement, door_open, door_closed, pending, busy
  );

  modport slave (
    input  req,
    output cur_floor, movement, door_open, door_closed, pending, busy
  );

endinterface

// File: rtl/lift_timer.sv
// lift_timer
//   Loadable down-counter shared by the travel and door phases.
//   Ports:
//     clk, rst   clock and asynchronous active-high reset (count -> 0)
//     load       load load_val this cycle (wins over counting)
//     load_val   value to load; a load of N gives expiry N cycles later
//     expired    high during the last cycle of a loaded interval
module lift_timer
  import lift_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  // Expiry is flagged on the count of one so that the owner can act on the
  // same edge the interval ends, giving exactly load_val cycles per phase.
  assign expired = (count == WIDTH'(1));

endmodule

// File: rtl/lift_scheduler.sv
// lift_scheduler
//   SCAN-style single-car lift controller.
//   Ports:
//     CLOCK_50   system clock, rising edge
//     RESET      asynchronous active-high reset
//     door_hold  (only with LIFT_DOOR_HOLD_EN) keeps the door open
//     bus        lift_scheduler_if.slave: req in; cur_floor, movement,
//                door_open, door_closed, pending, busy out (all registered)
//   Optional feature macro: LIFT_DOOR_HOLD_EN adds the door_hold input.
module lift_scheduler
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS    = 9,
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 150_000_000
) (
  input logic CLOCK_50,
  input logic RESET,
`ifdef LIFT_DOOR_HOLD_EN
  input logic door_hold,
`endif
  lift_scheduler_if.slave bus
);

  state_t                state, state_n;
  dir_t                  last_dir, dir_n;
  logic [3:0]            floor_q, floor_n;
  logic [NUM_FLOORS-1:0] pending_q, pending_n, eff;
  logic [NUM_FLOORS-1:0] here_m, above_m, below_m, up_next_m, dn_next_m;
  movement_t             movement_q;
  logic                  door_q, busy_q;
  logic                  tmr_load, tmr_expired;
  logic [TIMER_WIDTH-1:0] tmr_val;
  logic                  hit_here, hit_up_next, hit_dn_next;
  logic                  any_above, any_below, more_above, more_below;

  // Same-cycle requests take part in every decision.
  assign eff = pending_q | bus.req;

  // Floor masks relative to the current floor; the "next" masks look at the
  // floor being arrived at when a travel interval expires.
  always_comb begin
    here_m    = '0;
    above_m   = '0;
    below_m   = '0;
    up_next_m = '0;
    dn_next_m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      here_m[i]    = (i == int'(floor_q));
      above_m[i]   = (i > int'(floor_q));
      below_m[i]   = (i < int'(floor_q));
      up_next_m[i] = (i == int'(floor_q) + 1);
      dn_next_m[i] = (i == int'(floor_q) - 1);
    end
  end

  assign hit_here    = |(eff & here_m);
  assign hit_up_next = |(eff & up_next_m);
  assign hit_dn_next = |(eff & dn_next_m);
  assign any_above   = |(eff & above_m);
  assign any_below   = |(eff & below_m);
  assign more_above  = |(eff & above_m & ~up_next_m);
  assign more_below  = |(eff & below_m & ~dn_next_m);

  // The served floor is dropped from pending for as long as the door is open.
  assign pending_n = (state == DOOR_OPEN) ? (eff & ~here_m) : eff;

  always_comb begin
    state_n  = state;
    dir_n    = last_dir;
    floor_n  = floor_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE: begin
        if (hit_here) begin
          state_n  = DOOR_OPEN;
          tmr_load = 1'b1;
          tmr_val  = TIMER_WIDTH'(DOOR_CYCLES);
        end else if (any_above && (last_dir == DIR_UP || !any_below)) begin
          state_n  = MOVE_UP;
          dir_n    = DIR_UP;
          tmr_load = 1'b1;
          tmr_val  = TIMER_WIDTH'(TRAVEL_CYCLES);
        end else if (any_below) begin
          state_n  = MOVE_DOWN;
          dir_n    = DIR_DOWN;
          tmr_load = 1'b1;
          tmr_val  = TIMER_WIDTH'(TRAVEL_CYCLES);
        end
      end
      MOVE_UP: begin
        if (tmr_expired) begin
          floor_n = floor_q + 4'd1;
          if (hit_up_next) begin
            state_n  = DOOR_OPEN;
            tmr_load = 1'b1;
            tmr_val  = TIMER_WIDTH'(DOOR_CYCLES);
          end else if (more_above) begin
            tmr_load = 1'b1;
            tmr_val  = TIMER_WIDTH'(TRAVEL_CYCLES);
          end else begin
            // Unreachable while requests only clear at the door; kept so the
            // car can never run past the top floor.
            state_n = IDLE;
          end
        end
      end
      MOVE_DOWN: begin
        if (tmr_expired) begin
          floor_n = floor_q - 4'd1;
          if (hit_dn_next) begin
            state_n  = DOOR_OPEN;
            tmr_load = 1'b1;
            tmr_val  = TIMER_WIDTH'(DOOR_CYCLES);
          end else if (more_below) begin
            tmr_load = 1'b1;
            tmr_val  = TIMER_WIDTH'(TRAVEL_CYCLES);
          end else begin
            state_n = IDLE;
          end
        end
      end
      DOOR_OPEN: begin
`ifdef LIFT_DOOR_HOLD_EN
        if (door_hold) begin
          tmr_load = 1'b1;
          tmr_val  = TIMER_WIDTH'(DOOR_CYCLES);
        end else if (tmr_expired) begin
          state_n = IDLE;
        end
`else
        if (tmr_expired) begin
          state_n = IDLE;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Outputs are decoded from the next state so they line up with the state
  // register while staying free of any combinational path from req.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      last_dir   <= DIR_UP;
      floor_q    <= 4'd0;
      pending_q  <= '0;
      movement_q <= STOP;
      door_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      last_dir   <= dir_n;
      floor_q    <= floor_n;
      pending_q  <= pending_n;
      movement_q <= (state_n == MOVE_UP)   ? UP :
                    (state_n == MOVE_DOWN) ? DOWN : STOP;
      door_q     <= (state_n == DOOR_OPEN);
      busy_q     <= (state_n != IDLE) || (pending_n != '0);
    end
  end

  lift_timer #(
    .WIDTH(TIMER_WIDTH)
  ) u_timer (
    .clk     (CLOCK_50),
    .rst     (RESET),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expired (tmr_expired)
  );

  assign bus.cur_floor   = floor_q;
  assign bus.movement    = movement_q;
  assign bus.door_open   = door_q;
  assign bus.door_closed = ~door_q;
  assign bus.pending     = pending_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_lift_scheduler.sv
// tb_lift_scheduler
//   Directed scenarios plus a randomized request phase for lift_scheduler
//   (NUM_FLOORS=9, TRAVEL_CYCLES=4, DOOR_CYCLES=3). Every cycle the outputs
//   are compared with a behavioural model of the lift.
//   Honours LIFT_DOOR_HOLD_EN for the door hold scenario.
module tb_lift_scheduler;

  localparam int NF     = 9;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;
`ifdef LIFT_DOOR_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic RESET    = 1'b1;
  logic door_hold = 1'b0;

  int assert_count = 0;
  int fail_count   = 0;

  lift_scheduler_if #(.NUM_FLOORS(NF)) bus ();

  lift_scheduler #(
    .NUM_FLOORS   (NF),
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES  (DOOR)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
`ifdef LIFT_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Behavioural model: floor, direction of travel (+1/-1/0), door flag,
  // cycles left in the current activity and the outstanding request set.
  int          m_floor, m_dir, m_last, m_left;
  bit          m_door;
  bit [NF-1:0] m_pend;

  // Observation helpers used by the directed scenarios.
  int up_cycles, move_cycles, door_cycles;
  int door_floors[$];
  logic prev_door;

  function automatic bit requestsBeyond(input bit [NF-1:0] p, input int f,
                                        input int dir);
    for (int i = 0; i < NF; i++)
      if (p[i] && ((dir > 0) ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void modelReset();
    m_floor = 0; m_dir = 0; m_last = 1; m_left = 0; m_door = 0; m_pend = '0;
  endfunction

  function automatic void modelStep(input bit [NF-1:0] r, input bit hold);
    bit [NF-1:0] eff;
    bit up, dn;
    eff = m_pend | r;
    if (m_door) begin
      eff[m_floor] = 1'b0;
      m_pend = eff;
      if (HOLD_EN && hold) m_left = DOOR;
      else if (m_left <= 1) m_door = 0;
      else m_left--;
    end else if (m_dir != 0) begin
      m_pend = eff;
      if (m_left <= 1) begin
        m_floor += m_dir;
        if (eff[m_floor]) begin
          m_door = 1; m_dir = 0; m_left = DOOR;
        end else if (requestsBeyond(eff, m_floor, m_dir)) m_left = TRAVEL;
        else m_dir = 0;
      end else m_left--;
    end else begin
      m_pend = eff;
      if (eff[m_floor]) begin
        m_door = 1; m_left = DOOR;
      end else begin
        up = requestsBeyond(eff, m_floor, 1);
        dn = requestsBeyond(eff, m_floor, -1);
        if (up && (m_last == 1 || !dn)) begin
          m_dir = 1; m_last = 1; m_left = TRAVEL;
        end else if (dn) begin
          m_dir = -1; m_last = -1; m_left = TRAVEL;
        end
      end
    end
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    int exp_mv;
    exp_mv = (m_dir == 1) ? 1 : (m_dir == -1) ? 2 : 0;
    checkVal({tag, ".cur_floor"},   32'(bus.cur_floor),   32'(m_floor));
    checkVal({tag, ".movement"},    32'(bus.movement),    32'(exp_mv));
    checkVal({tag, ".door_open"},   32'(bus.door_open),   32'(m_door));
    checkVal({tag, ".door_closed"}, 32'(bus.door_closed), 32'(!m_door));
    checkVal({tag, ".pending"},     32'(bus.pending),     32'(m_pend));
    checkVal({tag, ".busy"},        32'(bus.busy),
             32'((m_dir != 0) || m_door || (m_pend != '0)));
  endtask

  // One clock: drive inputs, step the model on the edge, check 1 ns later.
  task automatic applyStimulus(input logic [NF-1:0] r, input logic hold,
                               input string tag);
    bus.req   = r;
    door_hold = hold;
    @(posedge CLOCK_50);
    modelStep(r, hold);
    #1;
    if (bus.movement === 2'd1) up_cycles++;
    if (bus.movement !== 2'd0) move_cycles++;
    if (bus.door_open === 1'b1) door_cycles++;
    if (bus.door_open === 1'b1 && prev_door !== 1'b1)
      door_floors.push_back(int'(bus.cur_floor));
    prev_door = bus.door_open;
    checkOutput(tag);
  endtask

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, tag);
  endtask

  task automatic resetDut();
    bus.req = '0; door_hold = 1'b0;
    RESET = 1'b1;
    @(posedge CLOCK_50);
    #1;
    modelReset();
    checkOutput("in_reset");
    RESET = 1'b0;
    up_cycles = 0; move_cycles = 0; door_cycles = 0;
    door_floors.delete();
    prev_door = 1'b0;
  endtask

  initial begin
    logic [NF-1:0] r;
    bus.req = '0;
    modelReset();

    // Single request from floor 0 up to floor 3.
    resetDut();
    checkVal("rst.cur_floor", 32'(bus.cur_floor), 32'd0);
    checkVal("rst.door_closed", 32'(bus.door_closed), 32'd1);
    applyStimulus(9'(1 << 3), 1'b0, "s1");
    idleCycles(20, "s1");
    checkVal("s1.up_cycles", 32'(up_cycles), 32'd12);
    checkVal("s1.door_cycles", 32'(door_cycles), 32'd3);
    checkVal("s1.door_floor", 32'(door_floors.size() > 0 ? door_floors[0] : -1), 32'd3);
    checkVal("s1.busy_end", 32'(bus.busy), 32'd0);
    checkVal("s1.pending_end", 32'(bus.pending), 32'd0);

    // Request at the current floor opens the door without moving.
    resetDut();
    applyStimulus(9'(1 << 0), 1'b0, "s2");
    checkVal("s2.door_next", 32'(bus.door_open), 32'd1);
    idleCycles(6, "s2");
    checkVal("s2.no_motion", 32'(move_cycles), 32'd0);

    // Requests on both sides with last direction up: serve 7 before 2.
    resetDut();
    applyStimulus(9'(1 << 4), 1'b0, "s3a");
    idleCycles(24, "s3a");
    checkVal("s3.at4", 32'(bus.cur_floor), 32'd4);
    door_floors.delete();
    applyStimulus(9'((1 << 2) | (1 << 7)), 1'b0, "s3b");
    idleCycles(50, "s3b");
    checkVal("s3.first_stop", 32'(door_floors.size() > 0 ? door_floors[0] : -1), 32'd7);
    checkVal("s3.second_stop", 32'(door_floors.size() > 1 ? door_floors[1] : -1), 32'd2);

    // Request appearing on the way up is served before the original target.
    resetDut();
    applyStimulus(9'(1 << 5), 1'b0, "s4");
    idleCycles(5, "s4");
    checkVal("s4.at1", 32'(bus.cur_floor), 32'd1);
    applyStimulus(9'(1 << 2), 1'b0, "s4");
    idleCycles(40, "s4");
    checkVal("s4.first_stop", 32'(door_floors.size() > 0 ? door_floors[0] : -1), 32'd2);
    checkVal("s4.second_stop", 32'(door_floors.size() > 1 ? door_floors[1] : -1), 32'd5);

    // Reset in the middle of travel discards everything.
    resetDut();
    applyStimulus(9'((1 << 5) | (1 << 6)), 1'b0, "s5");
    idleCycles(13, "s5");
    checkVal("s5.at3", 32'(bus.cur_floor), 32'd3);
    checkVal("s5.moving", 32'(bus.movement), 32'd1);
    #2 RESET = 1'b1;
    #1;
    checkVal("s5.rst_floor", 32'(bus.cur_floor), 32'd0);
    checkVal("s5.rst_pending", 32'(bus.pending), 32'd0);
    checkVal("s5.rst_movement", 32'(bus.movement), 32'd0);
    checkVal("s5.rst_door_closed", 32'(bus.door_closed), 32'd1);
    @(posedge CLOCK_50);
    #2 RESET = 1'b0;
    modelReset();
    idleCycles(6, "s5_after");
    checkVal("s5.after_floor", 32'(bus.cur_floor), 32'd0);
    checkVal("s5.after_door_closed", 32'(bus.door_closed), 32'd1);

    // Door hold keeps the door open and restarts the close time on release.
    if (HOLD_EN) begin
      resetDut();
      applyStimulus(9'(1 << 0), 1'b0, "s6");
      for (int i = 0; i < 10; i++) applyStimulus('0, 1'b1, "s6_hold");
      checkVal("s6.held_open", 32'(bus.door_open), 32'd1);
      idleCycles(2, "s6_rel");
      checkVal("s6.open_after_2", 32'(bus.door_open), 32'd1);
      idleCycles(1, "s6_rel");
      checkVal("s6.closed_after_3", 32'(bus.door_open), 32'd0);
    end

    // Randomized sparse requests against the model.
    resetDut();
    for (int c = 0; c < 500; c++) begin
      r = '0;
      if ($urandom_range(0, 5) == 0) r[$urandom_range(0, NF - 1)] = 1'b1;
      if ($urandom_range(0, 19) == 0) r[$urandom_range(0, NF - 1)] = 1'b1;
      applyStimulus(r, 1'($urandom_range(0, 3) == 0), "rand");
    end
    idleCycles(120, "drain");
    checkVal("drain.busy", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
